// File: rtl/sys_bus_router.sv
// rtl/sys_bus_router.sv - registered, handshaked LSU-to-peripheral router with timeout and bus-error bookkeeping
module sys_bus_router #(
   parameter int                      N_SLAVES  = 4,
   parameter logic [8*N_SLAVES-1:0]   SLAVE_IDS = 32'h07_03_01_00,
   parameter int                      TIMEOUT   = 16
) (
   input  logic                      clk_i,
   input  logic                      resetn_i,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [3:0]                be_i,
   input  logic [31:0]               addr_i,
   input  logic [31:0]               wd_i,
   output logic [31:0]               rd_o,
   output logic                      ready_o,
   output logic                      err_o,
   output logic [N_SLAVES-1:0]       s_req_o,
   output logic                      s_we_o,
   output logic [3:0]                s_be_o,
   output logic [31:0]               s_addr_o,
   output logic [31:0]               s_wd_o,
   input  logic [32*N_SLAVES-1:0]    s_rd_i,
   input  logic [N_SLAVES-1:0]       s_ready_i,
   output logic [7:0]                err_cnt_o,
   output logic [31:0]               err_addr_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_nx;
   logic [N_SLAVES-1:0]   hit_oh;
   logic [N_SLAVES-1:0]   sel_oh;
   logic                  sel_ready;
   logic [31:0]           sel_data;
   logic [31:0]           addr_q;
   logic [7:0]            cnt_q;
   logic                  go_resp;
   logic                  set_err;
   logic                  load_cnt;

   // Slot selection is kept one-hot so the ready/data muxes are plain AND-OR trees.
   always_comb begin
      hit_oh    = '0;
      sel_data  = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         hit_oh[k] = (addr_i[31:24] == SLAVE_IDS[8*k +: 8]);
         sel_data  = sel_data | (s_rd_i[32*k +: 32] & {32{sel_oh[k]}});
      end
      sel_ready = |(s_ready_i & sel_oh);
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) state_q <= S_IDLE;
      else           state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      go_resp  = 1'b0;
      set_err  = 1'b0;
      load_cnt = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               if (|hit_oh) begin
                  state_nx = S_ACCESS;
               end else begin
                  state_nx = S_RESP;
                  go_resp  = 1'b1;
                  set_err  = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            if (sel_ready) begin
               state_nx = S_RESP;
               go_resp  = 1'b1;
            end else begin
               state_nx = S_WAIT;
               load_cnt = 1'b1;
            end
         end
         S_WAIT: begin
            // Ready wins over an expiring counter.
            if (sel_ready) begin
               state_nx = S_RESP;
               go_resp  = 1'b1;
            end else if (cnt_q == 8'd0) begin
               state_nx = S_RESP;
               go_resp  = 1'b1;
               set_err  = 1'b1;
            end
         end
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         rd_o       <= '0;
         ready_o    <= 1'b0;
         err_o      <= 1'b0;
         s_req_o    <= '0;
         s_we_o     <= 1'b0;
         s_be_o     <= '0;
         s_addr_o   <= '0;
         s_wd_o     <= '0;
         err_cnt_o  <= '0;
         err_addr_o <= '0;
         sel_oh     <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
      end else begin
         ready_o <= go_resp;
         err_o   <= go_resp & set_err;
         s_req_o <= (state_q == S_IDLE && req_i) ? hit_oh : '0;

         if (state_q == S_IDLE && req_i) begin
            s_we_o   <= we_i;
            s_be_o   <= be_i;
            s_addr_o <= {8'h00, addr_i[23:0]};
            s_wd_o   <= wd_i;
            addr_q   <= addr_i;
            sel_oh   <= hit_oh;
         end

         if (load_cnt)
            cnt_q <= 8'(TIMEOUT - 1);
         else if (state_q == S_WAIT && cnt_q != 8'd0)
            cnt_q <= cnt_q - 8'd1;

         if (go_resp)
            rd_o <= (!set_err && !s_we_o) ? sel_data : '0;
         else if (state_q == S_RESP)
            rd_o <= '0;

         // A decode miss errors in the capture cycle, so addr_q is not yet valid there.
         if (go_resp && set_err) begin
            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            err_addr_o <= (state_q == S_IDLE) ? addr_i : addr_q;
         end
      end
   end

endmodule

// File: tb/tb_sys_bus_router.sv
// tb/tb_sys_bus_router.sv - directed self-checking bench for sys_bus_router
module tb_sys_bus_router;

   logic         clk_i = 1'b0;
   logic         resetn_i;
   logic         req_i;
   logic         we_i;
   logic [3:0]   be_i;
   logic [31:0]  addr_i;
   logic [31:0]  wd_i;
   logic [31:0]  rd_o;
   logic         ready_o;
   logic         err_o;
   logic [3:0]   s_req_o;
   logic         s_we_o;
   logic [3:0]   s_be_o;
   logic [31:0]  s_addr_o;
   logic [31:0]  s_wd_o;
   logic [127:0] s_rd_i;
   logic [3:0]   s_ready_i;
   logic [7:0]   err_cnt_o;
   logic [31:0]  err_addr_o;

   int checks   = 0;
   int failures = 0;
   int cyc;

   sys_bus_router #(.N_SLAVES(4), .SLAVE_IDS(32'h07_03_01_00), .TIMEOUT(16)) dut (
      .clk_i(clk_i), .resetn_i(resetn_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wd_i(wd_i), .rd_o(rd_o), .ready_o(ready_o), .err_o(err_o),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
      .s_wd_o(s_wd_o), .s_rd_i(s_rd_i), .s_ready_i(s_ready_i),
      .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Called in an idle cycle (cycle 0); returns in cycle 1 with req_i dropped.
   task automatic start(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd);
      we_i = we; be_i = be; addr_i = addr; wd_i = wd; req_i = 1'b1;
      tick();
      req_i = 1'b0;
   endtask

   task automatic wait_ready(input int max, output int n);
      n = 1;
      while (ready_o !== 1'b1 && n < max) begin
         tick();
         n++;
      end
   endtask

   initial begin
      resetn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wd_i = '0;
      s_rd_i = '0; s_ready_i = '0;
      s_rd_i[31:0]   = 32'hCAFE_F00D;
      s_rd_i[63:32]  = 32'h1111_2222;
      s_rd_i[95:64]  = 32'h3333_4444;
      s_rd_i[127:96] = 32'h5555_6666;
      #12;
      chk("rst_rd", rd_o, 32'h0);
      chk("rst_ctl", 32'({ready_o, err_o, s_req_o, s_we_o, s_be_o}), 32'h0);
      chk("rst_saddr", s_addr_o, 32'h0);
      chk("rst_swd", s_wd_o, 32'h0);
      chk("rst_errcnt", 32'(err_cnt_o), 32'h0);
      chk("rst_erraddr", err_addr_o, 32'h0);
      tick();
      resetn_i = 1'b1;
      tick();

      // Read, slot 0, immediate ready
      s_ready_i = 4'b0001;
      start(1'b0, 4'hF, 32'h0000_0010, 32'h0);
      chk("rd0_sreq", 32'(s_req_o), 32'h1);
      chk("rd0_saddr", s_addr_o, 32'h10);
      chk("rd0_rdy_c1", 32'(ready_o), 32'h0);
      tick();
      chk("rd0_rdy", 32'({ready_o, err_o}), 32'h2);
      chk("rd0_data", rd_o, 32'hCAFE_F00D);
      s_ready_i = 4'b0000;
      tick();
      chk("rd0_after", 32'({ready_o, s_req_o}), 32'h0);

      // Write, slot 3, ready 3 cycles after s_req_o
      start(1'b1, 4'b0011, 32'h0700_0004, 32'h1234_5678);
      chk("wr3_sreq", 32'(s_req_o), 32'h8);
      chk("wr3_sbe", 32'(s_be_o), 32'h3);
      chk("wr3_swd", s_wd_o, 32'h1234_5678);
      chk("wr3_swe_saddr", 32'({s_we_o, s_addr_o[23:0]}), 32'h0100_0004);
      tick();
      chk("wr3_sreq_c2", 32'(s_req_o), 32'h0);
      tick();
      tick();
      s_ready_i = 4'b1000;
      chk("wr3_rdy_c4", 32'(ready_o), 32'h0);
      tick();
      s_ready_i = 4'b0000;
      chk("wr3_rdy_c5", 32'({ready_o, err_o}), 32'h2);
      chk("wr3_rd_zero", rd_o, 32'h0);
      tick();
      chk("wr3_hold_swd", s_wd_o, 32'h1234_5678);

      // Decode miss
      start(1'b0, 4'hF, 32'h0500_0000, 32'h0);
      chk("miss_rdy_err", 32'({ready_o, err_o}), 32'h3);
      chk("miss_sreq", 32'(s_req_o), 32'h0);
      chk("miss_errcnt", 32'(err_cnt_o), 32'h1);
      chk("miss_erraddr", err_addr_o, 32'h0500_0000);
      tick();
      chk("miss_after", 32'(ready_o), 32'h0);

      // Timeout on slot 2
      start(1'b0, 4'hF, 32'h0300_0008, 32'h0);
      chk("to_sreq", 32'(s_req_o), 32'h4);
      wait_ready(40, cyc);
      chk("to_latency", 32'(cyc), 32'd18);
      chk("to_err", 32'({ready_o, err_o}), 32'h3);
      chk("to_rd_zero", rd_o, 32'h0);
      chk("to_errcnt", 32'(err_cnt_o), 32'h2);
      chk("to_erraddr", err_addr_o, 32'h0300_0008);
      tick();

      // Ready arrives in the final WAIT cycle
      start(1'b0, 4'hF, 32'h0300_000C, 32'h0);
      for (int i = 0; i < 16; i++) tick();
      chk("race_c17", 32'(ready_o), 32'h0);
      s_ready_i = 4'b0100;
      tick();
      s_ready_i = 4'b0000;
      chk("race_rdy", 32'({ready_o, err_o}), 32'h2);
      chk("race_data", rd_o, 32'h3333_4444);
      chk("race_errcnt", 32'(err_cnt_o), 32'h2);
      tick();

      // Saturation of the error counter
      for (int i = 0; i < 300; i++) begin
         start(1'b0, 4'hF, 32'h0300_0000, 32'h0);
         wait_ready(40, cyc);
         tick();
      end
      chk("sat_errcnt", 32'(err_cnt_o), 32'hFF);

      // Reset pulsed during WAIT
      start(1'b0, 4'hF, 32'h0300_0010, 32'h0);
      for (int i = 0; i < 4; i++) tick();
      #1 resetn_i = 1'b0;
      #1;
      chk("wrst_ctl", 32'({ready_o, err_o, s_req_o, s_we_o, s_be_o}), 32'h0);
      chk("wrst_errcnt", 32'(err_cnt_o), 32'h0);
      chk("wrst_saddr", s_addr_o, 32'h0);
      chk("wrst_erraddr", err_addr_o, 32'h0);
      tick();
      resetn_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ready_o !== 1'b0) chk("wrst_no_ready", 32'(ready_o), 32'h0);
      end
      chk("wrst_quiet", 32'({ready_o, err_o, s_req_o}), 32'h0);
      s_ready_i = 4'b0010;
      start(1'b0, 4'hF, 32'h0100_0020, 32'h0);
      chk("post_sreq", 32'(s_req_o), 32'h2);
      tick();
      chk("post_rdy", 32'({ready_o, err_o}), 32'h2);
      chk("post_data", rd_o, 32'h1111_2222);
      s_ready_i = 4'b0000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sys_bus_router.md
# sys_bus_router

Parametrised system-bus router between the LSU memory port and up to N peripheral slots. It replaces the fixed combinational `addr[31:24]` decode and read-mux with a registered, handshaked transaction engine. The engine waits for each slave's ready, times out slaves that never answer, and reports decode misses and timeouts as bus errors with a saturating error counter and a captured fault address. It sits between `riscv_lsu` (`mem_*` side) and the memory and peripheral controllers inside the processor unit.

## Interface
Parameters:
- `N_SLAVES`, 4: number of slave slots, 1..8.
- `SLAVE_IDS`, 32'h07_03_01_00: packed 8-bit region IDs. Slot k owns `addr[31:24] == SLAVE_IDS[8k+7:8k]`. IDs are distinct.
- `TIMEOUT`, 16: cycles to wait for `s_ready_i` before error, 2..255.

Ports:
- `clk_i` in 1: system clock.
- `resetn_i` in 1: asynchronous, active-low reset.
- `req_i` in 1: master request.
- `we_i` in 1: master write enable.
- `be_i` in 4: byte enables.
- `addr_i` in 32: byte address.
- `wd_i` in 32: write data.
- `rd_o` out 32: read data, valid while `ready_o`.
- `ready_o` out 1: transaction complete, 1-cycle pulse.
- `err_o` out 1: bus error, qualified by `ready_o`.
- `s_req_o` out N_SLAVES: one-hot slave request.
- `s_we_o` out 1: captured `we`.
- `s_be_o` out 4: captured `be`.
- `s_addr_o` out 32: `{8'h00, addr[23:0]}`.
- `s_wd_o` out 32: captured write data.
- `s_rd_i` in 32*N_SLAVES: slot k data at `[32k+31:32k]`.
- `s_ready_i` in N_SLAVES: slot k ready.
- `err_cnt_o` out 8: saturating error count.
- `err_addr_o` out 32: full address of most recent error.

## Operation
- FSM has four states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - On `req_i` = 1, capture `we`, `be`, `addr` and `wd`, and decode `addr_i[31:24]` against `SLAVE_IDS`.
  - On a hit on slot k, latch k and go to ACCESS.
  - On a miss, set `err` and go to RESP.
- ACCESS:
  - Assert `s_req_o[k]` for exactly this one cycle. `s_we/be/addr/wd_o` are driven from the capture registers.
  - If `s_ready_i[k]` = 1 this cycle, go to RESP. Otherwise load the timeout counter with `TIMEOUT-1` and go to WAIT.
- WAIT:
  - `s_req_o` = 0.
  - If `s_ready_i[k]` = 1, go to RESP.
  - Else if the counter = 0, set `err` and go to RESP.
  - Else decrement the counter.
- Slave data capture: on the cycle `s_ready_i[k]` is seen, latch `s_rd_i[k]` into the `rd` register if it is a read. Writes latch 0.
- RESP:
  - `ready_o` = 1 and `err_o` = `err` for one cycle, then return to IDLE.
  - `rd_o` = latched data. On error or write, `rd_o` = 0.
- `req_i` is ignored outside IDLE. The master must drop or change `req_i` in the cycle after `ready_o`; a still-high `req_i` in IDLE starts a new transaction.
- `s_ready_i` of non-selected slots is ignored, as is `s_ready_i[k]` outside ACCESS/WAIT.
- Error bookkeeping (decode miss or timeout), on entry to RESP with `err`:
  - `err_cnt_o` += 1, saturating at 255.
  - `err_addr_o` = captured full address.
- Slave outputs `s_we/be/addr/wd_o` hold their last captured value when idle. `s_req_o` is the only qualifier.

## Timing
- Reset (asynchronous, immediate): state = IDLE.
  - All outputs 0: `rd_o`, `ready_o`, `err_o`, `s_req_o`, `s_we_o`, `s_be_o`, `s_addr_o`, `s_wd_o`, `err_cnt_o`, `err_addr_o`.
  - A transaction in flight is abandoned with no `ready_o`.
  - `s_req_o` drops combinationally with reset.
- Request sampled in cycle 0:
  - Slave with immediate ready: `s_req_o` in cycle 1, `ready_o` in cycle 2.
  - Slave ready in WAIT cycle j (j ≥ 1 after ACCESS): `ready_o` at cycle 2+j.
  - Decode miss: `ready_o` = `err_o` = 1 in cycle 1.
  - No-response slave: `s_req_o` in cycle 1, `ready_o` with `err_o` in cycle `TIMEOUT+2`.
- `s_ready_i[k]` arriving in the same cycle the counter reaches 0 is a success, not an error (ready has priority).
- All outputs are registered. No combinational path from `req_i` or `s_ready_i` to any output.
- `err_cnt_o` and `err_addr_o` update in the same cycle `ready_o`/`err_o` rise.

## Test plan
- Read, slot 0 (ID 00), `s_ready_i[0]` tied 1, `addr_i` = 32'h0000_0010, `s_rd_i[0]` = 32'hCAFE_F00D:
  - `s_req_o` = 4'b0001 in cycle 1 with `s_addr_o` = 32'h10.
  - `ready_o` in cycle 2 with `rd_o` = 32'hCAFE_F00D, `err_o` = 0.
- Write to slot 3 (ID 07), `addr_i` = 32'h0700_0004, `be_i` = 4'b0011, `wd_i` = 32'h1234_5678, slave ready 3 cycles after `s_req_o`:
  - `s_req_o` = 4'b1000 for 1 cycle with `s_be_o` = 4'b0011 and `s_wd_o` = 32'h1234_5678.
  - `ready_o` in cycle 5, `rd_o` = 0.
- `addr_i` = 32'h0500_0000 (unmapped):
  - `ready_o` = `err_o` = 1 in cycle 1, no `s_req_o`.
  - `err_cnt_o` = 1, `err_addr_o` = 32'h0500_0000.
- Slot 2 (ID 03) never ready, `TIMEOUT` = 16:
  - `ready_o` + `err_o` in cycle 18, `rd_o` = 0.
  - Repeat for 300 transactions: `err_cnt_o` saturates at 8'hFF.
- Ready-versus-timeout race: `s_ready_i[2]` asserted exactly in the final WAIT cycle (cycle 17) → `ready_o` in cycle 18 with `err_o` = 0 and slave data returned.
- `resetn_i` pulsed low during WAIT:
  - All outputs 0 immediately, FSM in IDLE, no `ready_o`.
  - A new request after release completes normally.
